// File: rtl/usb_rx_packer.sv
// USB receive packet assembler: LSB-first bits -> PID / payload / CRC16 fields with valid/ready.
// Optional CRC residual check compiled in with USB_RX_PACKER_CRC_CHECK_EN.
module usb_rx_packer #(
    parameter int MAX_DATA_BYTES = 8,
    localparam int CNT_W = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bit_in,
    input  logic                        bit_valid,
    input  logic                        eop,
    input  logic                        pkt_ready,
    output logic                        pkt_valid,
    output logic [7:0]                  pid,
    output logic [8*MAX_DATA_BYTES-1:0] data,
    output logic [CNT_W-1:0]            byte_count,
    output logic [15:0]                 crc16,
    output logic                        pid_err,
    output logic                        len_err,
    output logic                        crc_err,
    output logic                        overrun,
    output logic                        busy
);

    typedef enum logic [1:0] {IDLE, PID, BODY, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_BYTES);

    state_t                      state_q, state_d;
    logic [7:0]                  sr_q, sr_d;
    logic [2:0]                  bit_cnt_q, bit_cnt_d;
    logic [7:0]                  h0_q, h0_d, h1_q, h1_d;
    logic [1:0]                  hcnt_q, hcnt_d;
    logic [7:0]                  pid_q, pid_d;
    logic [8*MAX_DATA_BYTES-1:0] data_q, data_d;
    logic [CNT_W-1:0]            byte_count_q, byte_count_d;
    logic [15:0]                 crc16_q, crc16_d;
    logic                        pid_err_q, pid_err_d;
    logic                        len_err_q, len_err_d;
    logic                        overrun_q, overrun_d;
`ifdef USB_RX_PACKER_CRC_CHECK_EN
    logic [15:0]                 crc_q, crc_d;
    logic                        crc_err_q, crc_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        h0_d         = h0_q;
        h1_d         = h1_q;
        hcnt_d       = hcnt_q;
        pid_d        = pid_q;
        data_d       = data_q;
        byte_count_d = byte_count_q;
        crc16_d      = crc16_q;
        pid_err_d    = pid_err_q;
        len_err_d    = len_err_q;
        overrun_d    = 1'b0;
`ifdef USB_RX_PACKER_CRC_CHECK_EN
        crc_d        = crc_q;
        crc_err_d    = crc_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bit_valid) begin
                    sr_d         = {bit_in, 7'b0};
                    bit_cnt_d    = 3'd1;
                    hcnt_d       = 2'd0;
                    data_d       = '0;
                    byte_count_d = '0;
                    crc16_d      = '0;
                    pid_err_d    = 1'b0;
                    len_err_d    = 1'b0;
`ifdef USB_RX_PACKER_CRC_CHECK_EN
                    crc_err_d    = 1'b0;
`endif
                    state_d      = PID;
                    // a single-bit packet still reports its partial PID
                    if (eop) begin
                        pid_d     = sr_d;
                        len_err_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            PID: begin
                if (bit_valid) begin
                    sr_d      = {bit_in, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        pid_d     = sr_d;
                        pid_err_d = (sr_d[7:4] != ~sr_d[3:0]);
                        state_d   = BODY;
`ifdef USB_RX_PACKER_CRC_CHECK_EN
                        crc_d     = 16'hFFFF;
`endif
                    end
                end
                if (eop) begin
                    if (state_d != BODY) begin
                        pid_d     = sr_d;
                        len_err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            BODY: begin
                if (bit_valid) begin
                    sr_d      = {bit_in, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef USB_RX_PACKER_CRC_CHECK_EN
                    // reflected CRC16, poly 0x8005 -> 0xA001
                    crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ bit_in) ? 16'hA001 : 16'h0000);
`endif
                    if (bit_cnt_q == 3'd7) begin
                        // the last two bytes are held back: they may turn out to be the CRC
                        if (hcnt_q == 2'd2) begin
                            if (byte_count_q == MAX_CNT) begin
                                len_err_d = 1'b1;
                            end else begin
                                for (int k = 0; k < MAX_DATA_BYTES; k++)
                                    if (byte_count_q == CNT_W'(k)) data_d[8*k +: 8] = h1_q;
                                byte_count_d = byte_count_q + 1'b1;
                            end
                        end else begin
                            hcnt_d = hcnt_q + 2'd1;
                        end
                        h1_d = h0_q;
                        h0_d = sr_d;
                    end
                end
                if (eop) begin
                    crc16_d   = (hcnt_d == 2'd2) ? {h0_d, h1_d} : 16'h0000;
                    len_err_d = len_err_d | (bit_cnt_d != 3'd0) | (hcnt_d == 2'd1);
`ifdef USB_RX_PACKER_CRC_CHECK_EN
                    crc_err_d = (hcnt_d == 2'd2) && ({<<{crc_d}} != 16'h800D);
`endif
                    state_d   = DONE;
                end
            end
            DONE: begin
                overrun_d = bit_valid | eop;
                if (pkt_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            h0_q         <= '0;
            h1_q         <= '0;
            hcnt_q       <= '0;
            pid_q        <= '0;
            data_q       <= '0;
            byte_count_q <= '0;
            crc16_q      <= '0;
            pid_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef USB_RX_PACKER_CRC_CHECK_EN
            crc_q        <= '0;
            crc_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            h0_q         <= h0_d;
            h1_q         <= h1_d;
            hcnt_q       <= hcnt_d;
            pid_q        <= pid_d;
            data_q       <= data_d;
            byte_count_q <= byte_count_d;
            crc16_q      <= crc16_d;
            pid_err_q    <= pid_err_d;
            len_err_q    <= len_err_d;
            overrun_q    <= overrun_d;
`ifdef USB_RX_PACKER_CRC_CHECK_EN
            crc_q        <= crc_d;
            crc_err_q    <= crc_err_d;
`endif
        end
    end

    assign pkt_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign pid        = pid_q;
    assign data       = data_q;
    assign byte_count = byte_count_q;
    assign crc16      = crc16_q;
    assign pid_err    = pid_err_q;
    assign len_err    = len_err_q;
    assign overrun    = overrun_q;
`ifdef USB_RX_PACKER_CRC_CHECK_EN
    assign crc_err    = crc_err_q;
`else
    assign crc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_packer.sv
// Directed bench for usb_rx_packer (MAX_DATA_BYTES = 8).
module tb_usb_rx_packer;

    localparam int MAXB = 8;
    localparam int CW   = $clog2(MAXB + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            bit_in = 1'b0, bit_valid = 1'b0, eop = 1'b0, pkt_ready = 1'b0;
    logic            pkt_valid, pid_err, len_err, crc_err, overrun, busy;
    logic [7:0]      pid;
    logic [8*MAXB-1:0] data;
    logic [CW-1:0]   byte_count;
    logic [15:0]     crc16;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef USB_RX_PACKER_CRC_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    usb_rx_packer #(.MAX_DATA_BYTES(MAXB)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .eop(eop),
        .pkt_ready(pkt_ready), .pkt_valid(pkt_valid), .pid(pid), .data(data),
        .byte_count(byte_count), .crc16(crc16), .pid_err(pid_err), .len_err(len_err),
        .crc_err(crc_err), .overrun(overrun), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = b;
        eop       = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    // eop on its own cycle; returns at the negedge after it was sampled
    task automatic do_eop();
        @(negedge clk);
        bit_valid = 1'b0;
        eop       = 1'b1;
        chk("pre_eop_valid", 64'(pkt_valid), 64'd0);
        @(negedge clk);
        eop       = 1'b0;
    endtask

    task automatic accept();
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        chk("post_hs_valid", 64'(pkt_valid), 64'd0);
        chk("post_hs_busy", 64'(busy), 64'd0);
    endtask

    // USB CRC16 as transmitted: reflected 0x8005, init 0xFFFF, inverted
    function automatic logic [15:0] usb_crc(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
        logic [15:0] c;
        logic [23:0] s;
        c = 16'hFFFF;
        s = {b2, b1, b0};
        for (int i = 0; i < 24; i++) begin
            logic fb;
            fb = c[0] ^ s[i];
            c  = {1'b0, c[15:1]};
            if (fb) c = c ^ 16'hA001;
        end
        return ~c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;

        // reset state
        #12;
        chk("rst_valid", 64'(pkt_valid), 64'd0);
        chk("rst_pid", 64'(pid), 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_flags", {58'd0, busy, overrun, crc_err, len_err, pid_err, |byte_count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // DATA0 zero-length
        send_byte(8'hC3); send_byte(8'h00); send_byte(8'h00);
        do_eop();
        chk("d0_valid", 64'(pkt_valid), 64'd1);
        chk("d0_pid", 64'(pid), 64'hC3);
        chk("d0_cnt", 64'(byte_count), 64'd0);
        chk("d0_crc", 64'(crc16), 64'h0000);
        chk("d0_errs", {61'd0, pid_err, len_err, crc_err}, 64'd0);
        accept();

        // ACK held for 5 cycles
        send_byte(8'hD2);
        do_eop();
        chk("ack_pid", 64'(pid), 64'hD2);
        chk("ack_cnt_crc", {byte_count, crc16}, 64'd0);
        chk("ack_errs", {61'd0, pid_err, len_err, crc_err}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ack_hold", {busy, pkt_valid, pid}, {2'b11, 8'hD2});
        end
        accept();

        // token: two post-PID bytes reported as crc16
        send_byte(8'hE1); send_byte(8'h34); send_byte(8'h12);
        do_eop();
        chk("tok_crc", 64'(crc16), 64'h1234);
        chk("tok_cnt", 64'(byte_count), 64'd0);
        chk("tok_len", 64'(len_err), 64'd0);
        accept();

        // DATA1 with 3-byte payload and matching CRC
        c = usb_crc(8'h11, 8'h22, 8'h33);
        send_byte(8'h4B); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(c[7:0]); send_byte(c[15:8]);
        do_eop();
        chk("d1_data", data, 64'h0000_0000_0033_2211);
        chk("d1_cnt", 64'(byte_count), 64'd3);
        chk("d1_crc", 64'(crc16), 64'(c));
        chk("d1_errs", {61'd0, pid_err, len_err, crc_err}, 64'd0);
        accept();

        // same CRC, one payload bit flipped
        send_byte(8'h4B); send_byte(8'h10); send_byte(8'h22); send_byte(8'h33);
        send_byte(c[7:0]); send_byte(c[15:8]);
        do_eop();
        chk("bad_data", data, 64'h0000_0000_0033_2210);
        chk("bad_crcerr", 64'(crc_err), 64'(CRC_ON));
        accept();

        // overflow: 10 payload bytes + 2 CRC bytes
        send_byte(8'h4B);
        for (int i = 1; i <= 10; i++) send_byte(8'(i));
        send_byte(8'hAA); send_byte(8'h55);
        do_eop();
        chk("ovf_cnt", 64'(byte_count), 64'd8);
        chk("ovf_len", 64'(len_err), 64'd1);
        chk("ovf_data", data, 64'h0807_0605_0403_0201);
        chk("ovf_crc", 64'(crc16), 64'h55AA);
        accept();

        // misaligned: PID plus 7 bits
        send_byte(8'hC3);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        do_eop();
        chk("mis_len", 64'(len_err), 64'd1);
        chk("mis_cnt_crc", {byte_count, crc16}, 64'd0);
        accept();

        // bad PID with exactly one post-PID byte, then input while DONE
        send_byte(8'hC4); send_byte(8'h5A);
        do_eop();
        chk("bp_pid_err", 64'(pid_err), 64'd1);
        chk("bp_len", 64'(len_err), 64'd1);
        chk("bp_crc", 64'(crc16), 64'd0);
        @(negedge clk);
        bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        chk("ovr_pulse1", 64'(overrun), 64'd1);
        @(negedge clk);
        bit_valid = 1'b0;
        chk("ovr_pulse2", 64'(overrun), 64'd1);
        @(negedge clk);
        chk("ovr_clear", 64'(overrun), 64'd0);
        chk("ovr_fields", {pkt_valid, pid_err, len_err, pid, byte_count, crc16},
            {3'b111, 8'hC4, 4'd0, 16'd0});
        accept();

        // reset after 20 bits aborts the packet
        send_byte(8'h4B); send_byte(8'hFF);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk);
        bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_outs", {busy, pkt_valid, pid_err, len_err, overrun, pid, byte_count, crc16},
            64'd0);
        chk("abort_data", data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
        chk("abort_novalid", 64'(pkt_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
